gin_mc: RTL and testbench

GIN_MC -- requirements
Module: gin_mc

---
 rtl/gin_mc.sv | 140 ++++++++++++++
 tb/tb_gin_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gin_mc.sv
// rtl/gin_mc.sv - tag-matched multicast delivery of buffered packets onto a bus/PE grid
// Packets wait in a small FIFO; the head fires only when every matching PE is ready.
module gin_mc #(
  parameter int XBUS_NUMS  = 12,
  parameter int PE_NUMS    = 14,
  parameter int ID_LEN     = 5,
  parameter int ROW_LEN    = 4,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int N         = XBUS_NUMS * PE_NUMS,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 ready,
  input  logic [ROW_LEN-1:0]   row_tag,
  input  logic [ID_LEN-1:0]    col_tag,
  input  logic [VALUE_LEN-1:0] value,
  input  logic                 set_id,
  input  logic [ID_LEN-1:0]    id_scan_in,
  output logic [ID_LEN-1:0]    id_scan_out,
  input  logic                 set_row,
  input  logic [ROW_LEN-1:0]   row_scan_in,
  output logic [ROW_LEN-1:0]   row_scan_out,
  input  logic [N-1:0]         pe_ready,
  output logic [N-1:0]         pe_enable,
  output logic [VALUE_LEN-1:0] pe_value,
  output logic                 drop,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PKT_W = ROW_LEN + ID_LEN + VALUE_LEN;

  logic [PKT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PKT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_LEN-1:0]  id_q  [N];
  logic [ID_LEN-1:0]  id_d  [N];
  logic [ROW_LEN-1:0] row_q [XBUS_NUMS];
  logic [ROW_LEN-1:0] row_d [XBUS_NUMS];

  logic                 scan;
  logic                 not_empty;
  logic                 push;
  logic                 pop;
  logic                 fire;
  logic                 any_target;
  logic [N-1:0]         target;
  logic [ROW_LEN-1:0]   head_row;
  logic [ID_LEN-1:0]    head_col;
  logic [VALUE_LEN-1:0] head_val;

  assign {head_row, head_col, head_val} = mem_q[rd_ptr_q];

  assign scan      = set_id | set_row;
  assign not_empty = (count_q != '0);
  assign ready     = (count_q < CNT_W'(FIFO_DEPTH)) && !scan;
  assign push      = enable && ready;

  // All-ones tags act as broadcast wildcards on their own axis.
  always_comb begin
    target = '0;
    for (int b = 0; b < XBUS_NUMS; b++) begin
      for (int p = 0; p < PE_NUMS; p++) begin
        target[b*PE_NUMS+p] = ((head_row == row_q[b]) || (&head_row)) &&
                              ((head_col == id_q[b*PE_NUMS+p]) || (&head_col));
      end
    end
  end

  assign any_target = |target;
  assign fire       = not_empty && !scan && any_target && ((pe_ready & target) == target);
  assign drop       = not_empty && !scan && !any_target;
  assign pop        = fire || drop;

  assign pe_enable    = fire ? target : '0;
  assign pe_value     = head_val;
  assign occupancy    = count_q;
  assign id_scan_out  = id_q[N-1];
  assign row_scan_out = row_q[XBUS_NUMS-1];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {row_tag, col_tag, value};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    id_d  = id_q;
    row_d = row_q;
    if (set_id) begin
      id_d[0] = id_scan_in;
      for (int k = 1; k < N; k++) begin
        id_d[k] = id_q[k-1];
      end
    end
    if (set_row) begin
      row_d[0] = row_scan_in;
      for (int k = 1; k < XBUS_NUMS; k++) begin
        row_d[k] = row_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < N; i++)          id_q[i]  <= '0;
      for (int i = 0; i < XBUS_NUMS; i++)  row_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      id_q     <= id_d;
      row_q    <= row_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_gin_mc.sv
// tb/tb_gin_mc.sv - self-checking bench for gin_mc against a queue-based reference model
module tb_gin_mc;

  localparam int XB = 2;
  localparam int PE = 2;
  localparam int N  = XB * PE;
  localparam int D  = 4;
  localparam int IL = 5;
  localparam int RL = 4;
  localparam int VL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          ready;
  logic [RL-1:0] row_tag = '0;
  logic [IL-1:0] col_tag = '0;
  logic [VL-1:0] value = '0;
  logic          set_id = 1'b0;
  logic [IL-1:0] id_scan_in = '0;
  logic [IL-1:0] id_scan_out;
  logic          set_row = 1'b0;
  logic [RL-1:0] row_scan_in = '0;
  logic [RL-1:0] row_scan_out;
  logic [N-1:0]  pe_ready = '0;
  logic [N-1:0]  pe_enable;
  logic [VL-1:0] pe_value;
  logic          drop;
  logic [2:0]    occupancy;

  gin_mc #(
    .XBUS_NUMS(XB), .PE_NUMS(PE), .ID_LEN(IL), .ROW_LEN(RL),
    .VALUE_LEN(VL), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready(ready),
    .row_tag(row_tag), .col_tag(col_tag), .value(value),
    .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out),
    .set_row(set_row), .row_scan_in(row_scan_in), .row_scan_out(row_scan_out),
    .pe_ready(pe_ready), .pe_enable(pe_enable), .pe_value(pe_value),
    .drop(drop), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RL-1:0] row;
    logic [IL-1:0] col;
    logic [VL-1:0] val;
  } pkt_t;

  pkt_t          mq[$];
  logic [IL-1:0] mid  [N];
  logic [RL-1:0] mrow [XB];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++)  mid[i]  = '0;
    for (int i = 0; i < XB; i++) mrow[i] = '0;
  endtask

  // One clock: drive inputs after the falling edge, compare against the model, then advance it.
  task automatic cyc(input logic en, input logic [RL-1:0] rt, input logic [IL-1:0] ct,
                     input logic [VL-1:0] v, input logic sid, input logic [IL-1:0] idin,
                     input logic srow, input logic [RL-1:0] rowin, input logic [N-1:0] rdy);
    logic [N-1:0] tgt;
    bit scan_e, fire_e, drop_e, ready_e;
    @(negedge clk);
    enable = en; row_tag = rt; col_tag = ct; value = v;
    set_id = sid; id_scan_in = idin; set_row = srow; row_scan_in = rowin;
    pe_ready = rdy;
    #1;
    tgt = '0;
    if (mq.size() > 0) begin
      for (int b = 0; b < XB; b++)
        for (int p = 0; p < PE; p++)
          if ((mq[0].row == mrow[b] || mq[0].row == 4'hF) &&
              (mq[0].col == mid[b*PE+p] || mq[0].col == 5'h1F))
            tgt[b*PE+p] = 1'b1;
    end
    scan_e  = sid || srow;
    fire_e  = (mq.size() > 0) && !scan_e && (tgt != 0) && ((rdy & tgt) == tgt);
    drop_e  = (mq.size() > 0) && !scan_e && (tgt == 0);
    ready_e = (mq.size() < D) && !scan_e;
    chk("ready", ready, ready_e);
    chk("pe_enable", pe_enable, fire_e ? tgt : '0);
    chk("drop", drop, drop_e);
    chk("occupancy", occupancy, mq.size());
    chk("id_scan_out", id_scan_out, mid[N-1]);
    chk("row_scan_out", row_scan_out, mrow[XB-1]);
    if (fire_e) chk("pe_value", pe_value, mq[0].val);
    if (fire_e || drop_e) void'(mq.pop_front());
    if (en && ready_e) mq.push_back('{row: rt, col: ct, val: v});
    if (sid) begin
      for (int k = N - 1; k > 0; k--) mid[k] = mid[k-1];
      mid[0] = idin;
    end
    if (srow) begin
      for (int k = XB - 1; k > 0; k--) mrow[k] = mrow[k-1];
      mrow[0] = rowin;
    end
  endtask

  task automatic idle(input logic [N-1:0] rdy);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic send(input logic [RL-1:0] rt, input logic [IL-1:0] ct,
                      input logic [VL-1:0] v, input logic [N-1:0] rdy);
    cyc(1'b1, rt, ct, v, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [RL-1:0] rt;
    logic [IL-1:0] ct;
    logic [N-1:0]  rdy;
    model_reset();
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_pe_enable", pe_enable, 0);
    chk("rst_drop", drop, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Scan load: ROW = {0,1}, ID = {0,1,2,3}
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 4'd1, '1);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 4'd0, '1);
    for (int i = 3; i >= 0; i--) cyc(1'b0, '0, '0, '0, 1'b1, IL'(i), 1'b0, '0, '1);
    idle('1);
    chk("scan_row_out", row_scan_out, 4'd1);
    chk("scan_id_out", id_scan_out, 5'd3);

    // Unicast to bus 0, PE 1
    send(4'd0, 5'd1, 32'hA5A5_0001, '1);
    idle('1);
    chk("uni_pe_enable", pe_enable, 4'b0010);
    chk("uni_pe_value", pe_value, 32'hA5A5_0001);
    idle('1);
    chk("uni_occupancy", occupancy, 0);

    // Broadcast held under partial readiness
    send(4'hF, 5'h1F, 32'h0BCA_57ED, '1);
    idle(4'b0111);
    chk("mc_hold_en", pe_enable, 4'b0000);
    idle(4'b0111);
    chk("mc_hold_occ", occupancy, 1);
    idle(4'b1111);
    chk("mc_fire_en", pe_enable, 4'b1111);
    idle(4'b1111);
    chk("mc_once", pe_enable, 4'b0000);

    // Fill to full, then an unroutable packet is dropped at the head
    send(4'd0, 5'd0, 32'h1111_0001, '0);
    send(4'd2, 5'd0, 32'h1111_0002, '0);
    send(4'd0, 5'd0, 32'h1111_0003, '0);
    send(4'd0, 5'd0, 32'h1111_0004, '0);
    send(4'd0, 5'd0, 32'h1111_0005, '0);
    chk("full_ready", ready, 1'b0);
    chk("full_occ", occupancy, 4);
    idle(4'b0001);
    chk("full_first_fire", pe_enable, 4'b0001);
    idle(4'b0001);
    chk("drop_pulse", drop, 1'b1);
    chk("drop_no_en", pe_enable, 4'b0000);
    idle(4'b0001);
    chk("drop_once", drop, 1'b0);
    for (int i = 0; i < 3; i++) idle('1);

    // Reset mid-operation
    send(4'd0, 5'd0, 32'h2222_0001, '0);
    send(4'd0, 5'd0, 32'h2222_0002, '0);
    send(4'd0, 5'd0, 32'h2222_0003, '0);
    idle('0);
    chk("pre_rst_occ", occupancy, 3);
    #1 pe_ready = '1;
    #1 chk("pre_rst_en", pe_enable, 4'b0001);
    rst = 1'b0;
    #1;
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_en", pe_enable, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle('1);
    chk("post_rst_no_en", pe_enable, 4'b0000);
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b1, '0, 1'b1, '0, '1);
      chk("rst_scan_zero", {id_scan_out, row_scan_out}, 0);
    end

    // Randomized traffic including occasional scan activity
    for (int i = 0; i < 500; i++) begin
      rt  = ($urandom_range(0, 4) == 4) ? 4'hF : RL'($urandom_range(0, 2));
      ct  = ($urandom_range(0, 5) == 5) ? 5'h1F : IL'($urandom_range(0, 4));
      rdy = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      cyc(1'($urandom_range(0, 1)), rt, ct, $urandom,
          $urandom_range(0, 9) == 0, IL'($urandom_range(0, 3)),
          $urandom_range(0, 11) == 0, RL'($urandom_range(0, 2)), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
